// File: rtl/mips_pkg.sv
// mips_pkg: constants and types shared by the MIPS CPU blocks.
//   INSTR_WIDTH   instruction / address width
//   word_t        one machine word
//   RESET_VECTOR  first fetch address after reset
//   HALT_ADDRESS  a redirect to this address stops the CPU
//   fetch_state_e run / last-delivery / halted states of the fetch stage
package mips_pkg;

    localparam int INSTR_WIDTH = 32;

    typedef logic [INSTR_WIDTH-1:0] word_t;

    localparam word_t RESET_VECTOR = 32'hBFC00000;
    localparam word_t HALT_ADDRESS = 32'h00000000;

    // FS_LAST: fetch_pc already holds the halt (or bad) address; the next
    // advance retires the stage instead of delivering that word.
    typedef enum logic [1:0] {
        FS_RUN,
        FS_LAST,
        FS_HALTED
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: fetch-stage bus toward instruction memory and decode.
//   instr_address  fetch address to instruction memory
//   instr_read     memory data for the address presented on the previous edge
//   instr_out      instruction handed to decode
//   pc_out         address of instr_out
//   instr_valid    instr_out/pc_out are meaningful
//   stall          decode cannot consume this cycle
//   branch_taken   redirect request from decode (qualified by instr_valid)
//   branch_target  redirect address
// master = fetch stage, slave = memory/decode side.
interface instruction_fetch_if import mips_pkg::*; ();

    word_t instr_address;
    word_t instr_read;
    word_t instr_out;
    word_t pc_out;
    logic  instr_valid;
    logic  stall;
    logic  branch_taken;
    word_t branch_target;

    modport master (
        output instr_address, instr_out, pc_out, instr_valid,
        input  instr_read, stall, branch_taken, branch_target
    );

    modport slave (
        input  instr_address, instr_out, pc_out, instr_valid,
        output instr_read, stall, branch_taken, branch_target
    );

endinterface

// File: rtl/fetch_hold_buffer.sv
// fetch_hold_buffer: keeps the word under decode while decode stalls.
// The memory keeps reading the (unchanged) fetch address during a stall, so
// after the first stall edge instr_read already shows the successor word;
// the word in decode is captured on that first edge and replayed from here.
//   clk, reset   clock, synchronous active-high reset
//   capture      instr_valid && stall this cycle
//   clear        stage advances this cycle (word consumed)
//   instr_read   memory data
//   instr_out    held word while holding, otherwise instr_read
module fetch_hold_buffer import mips_pkg::*; (
    input  logic  clk,
    input  logic  reset,
    input  logic  capture,
    input  logic  clear,
    input  word_t instr_read,
    output word_t instr_out
);

    word_t hold;
    logic  hold_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold       <= '0;
            hold_valid <= 1'b0;
        end else if (clear) begin
            hold_valid <= 1'b0;
        end else if (capture && !hold_valid) begin
            hold       <= instr_read;
            hold_valid <= 1'b1;
        end
    end

    assign instr_out = hold_valid ? hold : instr_read;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC / fetch stage in front of a synchronous-read
// instruction memory. Pairs each returned word with its PC, honours the
// branch delay slot, holds the word across decode stalls and stops the CPU
// once execution is redirected to HALT_ADDRESS.
//   clk, reset     clock, synchronous active-high reset
//   bus            instruction_fetch_if.master (memory + decode handshake)
//   active         CPU running; 0 after halt until reset
//   address_error  misaligned redirect seen (sticky)
// Optional feature: FETCH_ALIGN_CHECK_EN -- a misaligned redirect target
// raises address_error and halts after the delay slot. Without it the low
// two target bits are dropped and address_error is tied low.
module instruction_fetch import mips_pkg::*; #(
    parameter word_t RESET_VECTOR = mips_pkg::RESET_VECTOR,
    parameter word_t HALT_ADDRESS = mips_pkg::HALT_ADDRESS
) (
    input  logic                       clk,
    input  logic                       reset,
    instruction_fetch_if.master        bus,
    output logic                       active,
    output logic                       address_error
);

    fetch_state_e state_q, state_d;

    word_t fetch_pc;
    word_t pc_q;
    logic  valid_q;
    logic  pend_q;
    word_t pend_target;

    logic  advance;
    logic  redirect_req;
    logic  take_redirect;
    word_t raw_target;
    word_t redirect_target;
    logic  misaligned;
    word_t next_pc;

    assign active        = (state_q != FS_HALTED);
    assign advance       = active && !(valid_q && bus.stall);
    assign redirect_req  = bus.branch_taken && valid_q;
    // A redirect latched during a stall wins over anything decode asks later.
    assign take_redirect = pend_q || redirect_req;
    assign raw_target    = pend_q ? pend_target : bus.branch_target;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_target = raw_target;
    assign misaligned      = take_redirect && (raw_target[1:0] != 2'b00);
`else
    assign redirect_target = raw_target & ~word_t'(3);
    assign misaligned      = 1'b0;
`endif

    assign next_pc = take_redirect ? redirect_target : fetch_pc + word_t'(4);

    // Run/halt control. fetch_pc takes the halt (or bad) address on one
    // advance so the delay-slot word still goes out; the next advance retires.
    always_ff @(posedge clk) begin
        if (reset) state_q <= FS_RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FS_RUN: begin
                if (advance && ((next_pc == HALT_ADDRESS) || misaligned))
                    state_d = FS_LAST;
            end
            FS_LAST: begin
                if (advance) state_d = FS_HALTED;
            end
            default: state_d = FS_HALTED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_VECTOR;
            pc_q        <= '0;
            valid_q     <= 1'b0;
            pend_q      <= 1'b0;
            pend_target <= '0;
        end else begin
            // Stalled redirect: remember it; the stall cannot coincide with advance.
            if (redirect_req && bus.stall && !pend_q) begin
                pend_q      <= 1'b1;
                pend_target <= bus.branch_target;
            end
            if (advance) begin
                pend_q <= 1'b0;
                if (state_q == FS_LAST) begin
                    valid_q <= 1'b0;
                end else begin
                    pc_q     <= fetch_pc;
                    valid_q  <= 1'b1;
                    fetch_pc <= next_pc;
                end
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (reset)                                        err_q <= 1'b0;
        else if (advance && state_q == FS_RUN && misaligned) err_q <= 1'b1;
    end
    assign address_error = err_q;
`else
    assign address_error = 1'b0;
`endif

    fetch_hold_buffer u_hold (
        .clk        (clk),
        .reset      (reset),
        .capture    (valid_q && bus.stall),
        .clear      (advance),
        .instr_read (bus.instr_read),
        .instr_out  (bus.instr_out)
    );

    assign bus.instr_address = fetch_pc;
    assign bus.pc_out        = pc_q;
    assign bus.instr_valid   = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed bench for instruction_fetch. The memory
// model returns each word equal to its address, one edge after sampling.
module tb_instruction_fetch;
    import mips_pkg::*;

    logic clk;
    logic reset;
    logic active;
    logic address_error;
    int   total = 0;
    int   bad   = 0;

    instruction_fetch_if bus();

    instruction_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .active        (active),
        .address_error (address_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous-read memory: M[a] = a
    always @(posedge clk) bus.instr_read <= bus.instr_address;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // leaves the bench in the first cycle with pc_out = BFC00000 valid
    task automatic do_reset();
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = '0;
        tick();
        tick();
        reset = 1'b0;
        total++; if (bus.instr_address !== 32'hBFC00000) begin bad++; $display("FAIL reset_addr got=%h exp=%h", bus.instr_address, 32'hBFC00000); end
        total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.instr_valid); end
        total++; if (bus.pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc_out got=%h exp=0", bus.pc_out); end
        total++; if (active !== 1'b1) begin bad++; $display("FAIL reset_active got=%b exp=1", active); end
        total++; if (address_error !== 1'b0) begin bad++; $display("FAIL reset_addr_err got=%b exp=0", address_error); end
        // branch with instr_valid=0 must be ignored
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'hBFC00400;
        tick();
        bus.branch_taken = 1'b0;
        total++; if (bus.pc_out !== 32'hBFC00000) begin bad++; $display("FAIL first_pc got=%h exp=%h", bus.pc_out, 32'hBFC00000); end
        total++; if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b exp=1", bus.instr_valid); end
        total++; if (bus.instr_out !== 32'hBFC00000) begin bad++; $display("FAIL first_instr got=%h exp=%h", bus.instr_out, 32'hBFC00000); end
        total++; if (bus.instr_address !== 32'hBFC00004) begin bad++; $display("FAIL ignore_branch_addr got=%h exp=%h", bus.instr_address, 32'hBFC00004); end
    endtask

    task automatic test_sequential();
        word_t exp;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            exp = 32'hBFC00000 + word_t'(4 * i);
            total++; if (bus.pc_out !== exp) begin bad++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, bus.pc_out, exp); end
            total++; if (bus.instr_out !== exp) begin bad++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, bus.instr_out, exp); end
            total++; if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, bus.instr_valid); end
            tick();
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.pc_out !== 32'hBFC00004) begin bad++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, bus.pc_out, 32'hBFC00004); end
            total++; if (bus.instr_out !== 32'hBFC00004) begin bad++; $display("FAIL stall_instr[%0d] got=%h exp=%h", i, bus.instr_out, 32'hBFC00004); end
            total++; if (bus.instr_address !== 32'hBFC00008) begin bad++; $display("FAIL stall_addr[%0d] got=%h exp=%h", i, bus.instr_address, 32'hBFC00008); end
            tick();
        end
        bus.stall = 1'b0;
        total++; if (bus.instr_out !== 32'hBFC00004) begin bad++; $display("FAIL release_instr got=%h exp=%h", bus.instr_out, 32'hBFC00004); end
        tick();
        total++; if (bus.pc_out !== 32'hBFC00008) begin bad++; $display("FAIL after_stall_pc got=%h exp=%h", bus.pc_out, 32'hBFC00008); end
        total++; if (bus.instr_out !== 32'hBFC00008) begin bad++; $display("FAIL after_stall_instr got=%h exp=%h", bus.instr_out, 32'hBFC00008); end
        tick();
        total++; if (bus.pc_out !== 32'hBFC0000C) begin bad++; $display("FAIL after_stall_pc2 got=%h exp=%h", bus.pc_out, 32'hBFC0000C); end
    endtask

    task automatic test_branch();
        do_reset();
        tick();
        tick();
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'hBFC00100;
        tick();
        bus.branch_taken = 1'b0;
        total++; if (bus.pc_out !== 32'hBFC0000C) begin bad++; $display("FAIL br_slot_pc got=%h exp=%h", bus.pc_out, 32'hBFC0000C); end
        total++; if (bus.instr_out !== 32'hBFC0000C) begin bad++; $display("FAIL br_slot_instr got=%h exp=%h", bus.instr_out, 32'hBFC0000C); end
        total++; if (bus.instr_address !== 32'hBFC00100) begin bad++; $display("FAIL br_addr got=%h exp=%h", bus.instr_address, 32'hBFC00100); end
        tick();
        total++; if (bus.pc_out !== 32'hBFC00100) begin bad++; $display("FAIL br_target_pc got=%h exp=%h", bus.pc_out, 32'hBFC00100); end
        total++; if (bus.instr_out !== 32'hBFC00100) begin bad++; $display("FAIL br_target_instr got=%h exp=%h", bus.instr_out, 32'hBFC00100); end
        tick();
        total++; if (bus.pc_out !== 32'hBFC00104) begin bad++; $display("FAIL br_next_pc got=%h exp=%h", bus.pc_out, 32'hBFC00104); end
    endtask

    task automatic test_branch_stall();
        do_reset();
        tick();
        tick();
        bus.stall = 1'b1;
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'hBFC00200;
        tick();
        // second request while pending must lose
        bus.branch_target = 32'hBFC00300;
        tick();
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        total++; if (bus.pc_out !== 32'hBFC00008) begin bad++; $display("FAIL brs_held_pc got=%h exp=%h", bus.pc_out, 32'hBFC00008); end
        total++; if (bus.instr_out !== 32'hBFC00008) begin bad++; $display("FAIL brs_held_instr got=%h exp=%h", bus.instr_out, 32'hBFC00008); end
        tick();
        total++; if (bus.pc_out !== 32'hBFC0000C) begin bad++; $display("FAIL brs_slot_pc got=%h exp=%h", bus.pc_out, 32'hBFC0000C); end
        total++; if (bus.instr_out !== 32'hBFC0000C) begin bad++; $display("FAIL brs_slot_instr got=%h exp=%h", bus.instr_out, 32'hBFC0000C); end
        tick();
        total++; if (bus.pc_out !== 32'hBFC00200) begin bad++; $display("FAIL brs_target_pc got=%h exp=%h", bus.pc_out, 32'hBFC00200); end
        total++; if (bus.instr_out !== 32'hBFC00200) begin bad++; $display("FAIL brs_target_instr got=%h exp=%h", bus.instr_out, 32'hBFC00200); end
    endtask

    task automatic test_halt();
        do_reset();
        repeat (4) tick();
        total++; if (bus.pc_out !== 32'hBFC00010) begin bad++; $display("FAIL halt_pre_pc got=%h exp=%h", bus.pc_out, 32'hBFC00010); end
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h00000000;
        tick();
        bus.branch_taken = 1'b0;
        total++; if (bus.pc_out !== 32'hBFC00014) begin bad++; $display("FAIL halt_slot_pc got=%h exp=%h", bus.pc_out, 32'hBFC00014); end
        total++; if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL halt_slot_valid got=%b exp=1", bus.instr_valid); end
        total++; if (active !== 1'b1) begin bad++; $display("FAIL halt_slot_active got=%b exp=1", active); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL halted_valid[%0d] got=%b exp=0", i, bus.instr_valid); end
            total++; if (active !== 1'b0) begin bad++; $display("FAIL halted_active[%0d] got=%b exp=0", i, active); end
            total++; if (bus.instr_address !== 32'h0) begin bad++; $display("FAIL halted_addr[%0d] got=%h exp=0", i, bus.instr_address); end
        end
        do_reset();
        total++; if (bus.pc_out !== 32'hBFC00000) begin bad++; $display("FAIL restart_pc got=%h exp=%h", bus.pc_out, 32'hBFC00000); end
        total++; if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL restart_valid got=%b exp=1", bus.instr_valid); end
        total++; if (active !== 1'b1) begin bad++; $display("FAIL restart_active got=%b exp=1", active); end
    endtask

    task automatic test_reset_midstall();
        do_reset();
        bus.stall = 1'b1;
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'hBFC00500;
        tick();
        tick();
        do_reset();
        total++; if (bus.instr_out !== 32'hBFC00000) begin bad++; $display("FAIL midstall_instr got=%h exp=%h", bus.instr_out, 32'hBFC00000); end
        tick();
        total++; if (bus.pc_out !== 32'hBFC00004) begin bad++; $display("FAIL midstall_pc got=%h exp=%h", bus.pc_out, 32'hBFC00004); end
        total++; if (bus.instr_out !== 32'hBFC00004) begin bad++; $display("FAIL midstall_next got=%h exp=%h", bus.instr_out, 32'hBFC00004); end
    endtask

    task automatic test_align();
        do_reset();
        tick();
        tick();
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'hBFC00102;
        tick();
        bus.branch_taken = 1'b0;
        total++; if (bus.pc_out !== 32'hBFC0000C) begin bad++; $display("FAIL align_slot_pc got=%h exp=%h", bus.pc_out, 32'hBFC0000C); end
        total++; if (bus.instr_valid !== 1'b1) begin bad++; $display("FAIL align_slot_valid got=%b exp=1", bus.instr_valid); end
        tick();
`ifdef FETCH_ALIGN_CHECK_EN
        total++; if (address_error !== 1'b1) begin bad++; $display("FAIL align_err got=%b exp=1", address_error); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL align_active got=%b exp=0", active); end
        total++; if (bus.instr_valid !== 1'b0) begin bad++; $display("FAIL align_valid got=%b exp=0", bus.instr_valid); end
        tick();
        total++; if (address_error !== 1'b1) begin bad++; $display("FAIL align_err_sticky got=%b exp=1", address_error); end
`else
        total++; if (bus.pc_out !== 32'hBFC00100) begin bad++; $display("FAIL align_mask_pc got=%h exp=%h", bus.pc_out, 32'hBFC00100); end
        total++; if (bus.instr_out !== 32'hBFC00100) begin bad++; $display("FAIL align_mask_instr got=%h exp=%h", bus.instr_out, 32'hBFC00100); end
        total++; if (address_error !== 1'b0) begin bad++; $display("FAIL align_err got=%b exp=0", address_error); end
        total++; if (active !== 1'b1) begin bad++; $display("FAIL align_active got=%b exp=1", active); end
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_branch_stall();
        test_halt();
        test_reset_midstall();
        test_align();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
